// File: rtl/mat_result_drain.sv
// Streams a ROWS x COLS result matrix out of the accumulator buffer onto a valid/ready port.
// A 2-entry FIFO hides the 1-cycle read latency; reads are credit-limited so it never overflows.
module mat_result_drain #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_major,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_line_last,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL = ROWS * COLS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int R_W   = $clog2(ROWS + 1);
    localparam int C_W   = $clog2(COLS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        state_r;
    logic              col_major_r;
    logic [ADDR_W-1:0] base_r;
    logic [R_W-1:0]    row_r;
    logic [C_W-1:0]    col_r;
    logic [CNT_W-1:0]  issued_r;
    logic              inflight_r;
    logic              infl_line_r;
    logic              infl_last_r;
    logic [DATA_W-1:0] fifo_data_r [2];
    logic [1:0]        fifo_line_r;
    logic [1:0]        fifo_last_r;
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              done_r;

    logic              pop_s;
    logic              issue_s;
    logic              row_end_s;
    logic              col_end_s;
    logic              line_last_s;
    logic              last_s;
    logic [ADDR_W-1:0] offset_s;

    // Issue credit: free FIFO slots minus the read still returning, plus the slot freed by this cycle's pop.
    always_comb begin
        pop_s   = (count_r != 2'd0) && out_ready;
        issue_s = 1'b0;
        if (state_r == ST_RUN) begin
            issue_s = ({1'b0, count_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s});
        end else begin
            issue_s = 1'b0;
        end
        row_end_s   = (row_r == R_W'(ROWS - 1));
        col_end_s   = (col_r == C_W'(COLS - 1));
        line_last_s = col_major_r ? row_end_s : col_end_s;
        last_s      = (issued_r == CNT_W'(TOTAL - 1));
        offset_s    = ADDR_W'(row_r) * ADDR_W'(COLS) + ADDR_W'(col_r);
    end

    assign mem_rd_en     = issue_s;
    assign mem_rd_addr   = base_r + offset_s;
    assign out_valid     = (count_r != 2'd0);
    assign out_data      = fifo_data_r[rd_ptr_r];
    assign out_line_last = fifo_line_r[rd_ptr_r];
    assign out_last      = fifo_last_r[rd_ptr_r];
    assign busy          = (state_r != ST_IDLE);
    assign done          = done_r;

    // Drain sequencing: latch the run setup, walk the element counters, finish on the last transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            col_major_r <= 1'b0;
            base_r      <= {ADDR_W{1'b0}};
            row_r       <= {R_W{1'b0}};
            col_r       <= {C_W{1'b0}};
            issued_r    <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        col_major_r <= col_major;
                        base_r      <= base_addr;
                        row_r       <= {R_W{1'b0}};
                        col_r       <= {C_W{1'b0}};
                        issued_r    <= {CNT_W{1'b0}};
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        issued_r <= issued_r + CNT_W'(1);
                        if (col_major_r) begin
                            if (row_end_s) begin
                                row_r <= {R_W{1'b0}};
                                col_r <= col_r + C_W'(1);
                            end else begin
                                row_r <= row_r + R_W'(1);
                            end
                        end else begin
                            if (col_end_s) begin
                                col_r <= {C_W{1'b0}};
                                row_r <= row_r + R_W'(1);
                            end else begin
                                col_r <= col_r + C_W'(1);
                            end
                        end
                        if (last_s) begin
                            state_r <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (pop_s && out_last) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-return capture into the 2-entry FIFO; tags travel with the read issued one cycle earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r     <= 1'b0;
            infl_line_r    <= 1'b0;
            infl_last_r    <= 1'b0;
            fifo_data_r[0] <= {DATA_W{1'b0}};
            fifo_data_r[1] <= {DATA_W{1'b0}};
            fifo_line_r    <= 2'b00;
            fifo_last_r    <= 2'b00;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
        end else begin
            inflight_r  <= issue_s;
            infl_line_r <= line_last_s;
            infl_last_r <= last_s;
            if (inflight_r) begin
                fifo_data_r[wr_ptr_r] <= mem_rd_data;
                fifo_line_r[wr_ptr_r] <= infl_line_r;
                fifo_last_r[wr_ptr_r] <= infl_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_mat_result_drain.sv
// Randomized self-checking bench for mat_result_drain: a memory model feeds the read port and
// the drained stream is compared with the expected matrix traversal order.
module tb_mat_result_drain;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        col_major = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_line_last;
    logic        out_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    mat_result_drain #(.DATA_W(32), .ROWS(ROWS), .COLS(COLS), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .col_major(col_major), .base_addr(base_addr),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_line_last(out_line_last), .out_last(out_last), .busy(busy), .done(done)
    );

    logic [31:0] mem_model [256];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit mon_en = 1'b0;

    int          tb_buf = 0;
    bit          tb_infl = 1'b0;
    bit          prev_stall = 1'b0;
    logic [33:0] prev_head = 34'h0;
    int          viol_valid = 0;
    int          viol_over = 0;
    int          viol_stable = 0;
    logic        s_rden = 1'b0;
    logic [7:0]  s_addr = 8'h00;

    logic [33:0] xfer_q [$];
    int          xfer_cyc [$];
    logic [7:0]  rd_addr_q [$];
    int          rd_cyc [$];
    int          done_cyc [$];
    logic        done_busy [$];

    wire pop_w = out_valid && out_ready;

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator buffer model: data valid exactly one cycle after the read, garbage otherwise.
    always @(posedge clk) mem_rd_data <= s_rden ? mem_model[s_addr] : $urandom;

    // Interface monitor: occupancy model, stall stability, and logging of reads/transfers/done.
    always @(negedge clk) begin
        s_rden <= mem_rd_en;
        s_addr <= mem_rd_addr;
        if (mon_en) begin
            if (out_valid !== (tb_buf != 0)) viol_valid <= viol_valid + 1;
            if (mem_rd_en === 1'b1 && (tb_buf + int'(tb_infl) - int'(pop_w)) >= 2) viol_over <= viol_over + 1;
            if (prev_stall && (out_valid !== 1'b1 || {out_data, out_line_last, out_last} !== prev_head))
                viol_stable <= viol_stable + 1;
            prev_stall <= out_valid && !out_ready && !rst;
            prev_head  <= {out_data, out_line_last, out_last};
            if (pop_w) begin
                xfer_q.push_back({out_data, out_line_last, out_last});
                xfer_cyc.push_back(cyc - t0);
            end
            if (mem_rd_en) begin
                rd_addr_q.push_back(mem_rd_addr);
                rd_cyc.push_back(cyc - t0);
            end
            if (done) begin
                done_cyc.push_back(cyc - t0);
                done_busy.push_back(busy);
            end
            if (rst) begin
                tb_buf  <= 0;
                tb_infl <= 1'b0;
            end else begin
                tb_buf  <= tb_buf + int'(tb_infl) - int'(pop_w);
                tb_infl <= mem_rd_en;
            end
        end
    end

    task automatic fill_mem(input bit rnd);
        for (int a = 0; a < 256; a++)
            mem_model[a] = rnd ? $urandom : (32'h1000 + ((a - 16) & 255));
    endtask

    task automatic run_drain(input bit cm, input logic [7:0] base, input bit rnd, input bit noise,
                             output int xb, output int rb, output int db, output int vb);
        bit finished = 1'b0;
        xb = xfer_q.size();
        rb = rd_addr_q.size();
        db = done_cyc.size();
        vb = viol_valid + viol_over + viol_stable;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        col_major = cm;
        base_addr = base;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int k = 1; k < 400 && !finished; k++) begin
            @(posedge clk); #1;
            start = noise && (k == 5 || k == N + 2);
            col_major = 1'($urandom);
            base_addr = 8'($urandom);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done_cyc.size() > db) finished = 1'b1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL drain_timeout: done seen=%0d required=1", finished);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic verify_stream(input string tag, input bit cm, input logic [7:0] base, input bit full,
                                 input int xb, input int rb, input int db, input int vb);
        int nx = xfer_q.size() - xb;
        int nr = rd_addr_q.size() - rb;
        int nd = done_cyc.size() - db;
        int nv = viol_valid + viol_over + viol_stable - vb;
        checks++;
        if (nx != N) begin errors++; $display("FAIL %s xfer_count got=%0d exp=%0d", tag, nx, N); end
        for (int k = 0; k < N; k++) begin
            int r = cm ? (k % ROWS) : (k / COLS);
            int c = cm ? (k / ROWS) : (k % COLS);
            logic [7:0] a = 8'(int'(base) + r * COLS + c);
            logic [33:0] exp_e = {mem_model[a], cm ? (r == ROWS - 1) : (c == COLS - 1), k == N - 1};
            if (k < nx) begin
                checks++;
                if (xfer_q[xb + k] !== exp_e) begin
                    errors++;
                    $display("FAIL %s elem%0d got=%h exp=%h", tag, k, xfer_q[xb + k], exp_e);
                end
            end
            if (k < nr) begin
                checks++;
                if (rd_addr_q[rb + k] !== a) begin
                    errors++;
                    $display("FAIL %s addr%0d got=%h exp=%h", tag, k, rd_addr_q[rb + k], a);
                end
            end
        end
        checks++;
        if (nr != N) begin errors++; $display("FAIL %s read_count got=%0d exp=%0d", tag, nr, N); end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL %s done_count got=%0d exp=1", tag, nd); end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL %s protocol valid=%0d over=%0d stable=%0d exp=0", tag, viol_valid, viol_over, viol_stable);
        end
        if (full) begin
            for (int k = 0; k < nx && k < N; k++) begin
                checks++;
                if (xfer_cyc[xb + k] != 3 + k) begin
                    errors++;
                    $display("FAIL %s xfer_cycle%0d got=%0d exp=%0d", tag, k, xfer_cyc[xb + k], 3 + k);
                end
            end
            if (nd >= 1) begin
                checks++;
                if (done_cyc[db] != 3 + N) begin errors++; $display("FAIL %s done_cycle got=%0d exp=%0d", tag, done_cyc[db], 3 + N); end
                checks++;
                if (done_busy[db] !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got=%b exp=0", tag, done_busy[db]); end
            end
            if (nr >= 1) begin
                checks++;
                if (rd_cyc[rb] != 1) begin errors++; $display("FAIL %s first_read_cycle got=%0d exp=1", tag, rd_cyc[rb]); end
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        @(posedge clk); #1;
        @(posedge clk); #1;
        outs = {mem_rd_en, mem_rd_addr, out_valid, out_data[17:0], out_line_last, out_last, busy, done};
        checks++;
        if (outs !== 32'h0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got=%h data=%h exp=0", outs, out_data);
        end
        checks++;
        if (mem_rd_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", mem_rd_addr); end
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b valid=%b exp=0", busy, out_valid);
        end
    endtask

    task automatic test_row_major();
        int xb, rb, db, vb;
        logic [33:0] e;
        fill_mem(1'b0);
        run_drain(1'b0, 8'h10, 1'b0, 1'b0, xb, rb, db, vb);
        verify_stream("row_major", 1'b0, 8'h10, 1'b1, xb, rb, db, vb);
        if (xfer_q.size() >= xb + N) begin
            e = xfer_q[xb];
            checks++;
            if (e !== {32'h1000, 1'b0, 1'b0}) begin errors++; $display("FAIL row_first got=%h exp=%h", e, {32'h1000, 2'b00}); end
            e = xfer_q[xb + 3];
            checks++;
            if (e !== {32'h1003, 1'b1, 1'b0}) begin errors++; $display("FAIL row_line_end got=%h exp=%h", e, {32'h1003, 2'b10}); end
            e = xfer_q[xb + N - 1];
            checks++;
            if (e !== {32'h100F, 1'b1, 1'b1}) begin errors++; $display("FAIL row_last got=%h exp=%h", e, {32'h100F, 2'b11}); end
        end
    endtask

    task automatic test_col_major();
        int xb, rb, db, vb;
        logic [33:0] e;
        logic [7:0] a;
        fill_mem(1'b0);
        run_drain(1'b1, 8'h10, 1'b0, 1'b0, xb, rb, db, vb);
        verify_stream("col_major", 1'b1, 8'h10, 1'b1, xb, rb, db, vb);
        if (xfer_q.size() >= xb + N && rd_addr_q.size() >= rb + N) begin
            e = xfer_q[xb + 1];
            checks++;
            if (e !== {32'h1004, 1'b0, 1'b0}) begin errors++; $display("FAIL col_second got=%h exp=%h", e, {32'h1004, 2'b00}); end
            a = rd_addr_q[rb + 4];
            checks++;
            if (a !== 8'h11) begin errors++; $display("FAIL col_addr4 got=%h exp=11", a); end
        end
    endtask

    task automatic test_random_ready();
        int xb, rb, db, vb;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] base = 8'($urandom);
            bit cm = 1'(i);
            fill_mem(1'b1);
            run_drain(cm, base, 1'b1, 1'b0, xb, rb, db, vb);
            verify_stream("random_ready", cm, base, 1'b0, xb, rb, db, vb);
        end
    endtask

    task automatic test_wrap();
        int xb, rb, db, vb;
        logic [7:0] a;
        fill_mem(1'b1);
        run_drain(1'b0, 8'hFE, 1'b0, 1'b0, xb, rb, db, vb);
        verify_stream("wrap", 1'b0, 8'hFE, 1'b1, xb, rb, db, vb);
        if (rd_addr_q.size() >= rb + N) begin
            a = rd_addr_q[rb + 2];
            checks++;
            if (a !== 8'h00) begin errors++; $display("FAIL wrap_addr2 got=%h exp=00", a); end
            a = rd_addr_q[rb + N - 1];
            checks++;
            if (a !== 8'h0D) begin errors++; $display("FAIL wrap_addr_last got=%h exp=0D", a); end
        end
    endtask

    task automatic test_mid_reset();
        int xb, rb, db, vb;
        int late_rd = 0;
        int late_x = 0;
        int rb0 = rd_addr_q.size();
        int xb0 = xfer_q.size();
        fill_mem(1'b1);
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b1;
        col_major = 1'b0;
        base_addr = 8'h20;
        out_ready = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst = (k == 8);
            if (k == 9) begin
                @(negedge clk);
                checks++;
                if ({mem_rd_en, mem_rd_addr, out_valid, out_line_last, out_last, busy, done} !== 14'h0 || out_data !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_reset_outputs rd_en=%b addr=%h valid=%b data=%h ll=%b last=%b busy=%b done=%b exp=all0",
                             mem_rd_en, mem_rd_addr, out_valid, out_data, out_line_last, out_last, busy, done);
                end
            end
        end
        rst = 1'b0;
        for (int i = rb0; i < rd_addr_q.size(); i++) if (rd_cyc[i] >= 9) late_rd++;
        for (int i = xb0; i < xfer_q.size(); i++) if (xfer_cyc[i] >= 9) late_x++;
        checks++;
        if (late_rd != 0 || late_x != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet reads=%0d xfers=%0d exp=0", late_rd, late_x);
        end
        checks++;
        if (rd_addr_q.size() - rb0 != 8) begin
            errors++;
            $display("FAIL mid_reset_reads_before got=%0d exp=8", rd_addr_q.size() - rb0);
        end
        run_drain(1'b0, 8'h20, 1'b0, 1'b0, xb, rb, db, vb);
        verify_stream("after_reset", 1'b0, 8'h20, 1'b1, xb, rb, db, vb);
    endtask

    task automatic test_start_ignored();
        int xb, rb, db, vb;
        fill_mem(1'b1);
        run_drain(1'b0, 8'h40, 1'b0, 1'b1, xb, rb, db, vb);
        verify_stream("start_ignored", 1'b0, 8'h40, 1'b1, xb, rb, db, vb);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_ignored_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int xb, rb, db, vb;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] base = 8'($urandom);
            fill_mem(1'b1);
            run_drain(1'(~i), base, 1'b1, 1'b0, xb, rb, db, vb);
            verify_stream("back_to_back", 1'(~i), base, 1'b0, xb, rb, db, vb);
        end
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_col_major();
        test_random_ready();
        test_wrap();
        test_mid_reset();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
